// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: widths, GF(2^8) multiply helpers and the engine FSM states.
// The inverse-mode multipliers are only referenced when INV_MIX_COLUMNS_EN is defined.
package aes_pkg;

    localparam int BYTE     = 8;
    localparam int WORD     = 4 * BYTE;
    localparam int SENTENCE = 4 * WORD;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } fsm_t;

    // Packed view of the state: index 3 is column 0 (the MSB word), index 0 is column 3.
    typedef logic [3:0][WORD-1:0] state_t;

    // Multiply by x modulo the AES polynomial 0x11B.
    function automatic logic [BYTE-1:0] gf_xtime(input logic [BYTE-1:0] b);
        return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [BYTE-1:0] gf_mul2(input logic [BYTE-1:0] b);
        return gf_xtime(b);
    endfunction

    function automatic logic [BYTE-1:0] gf_mul3(input logic [BYTE-1:0] b);
        return gf_xtime(b) ^ b;
    endfunction

    function automatic logic [BYTE-1:0] gf_mul9(input logic [BYTE-1:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ b;
    endfunction

    function automatic logic [BYTE-1:0] gf_mul11(input logic [BYTE-1:0] b);
        logic [BYTE-1:0] x2;
        x2 = gf_xtime(b);
        return gf_xtime(gf_xtime(x2)) ^ x2 ^ b;
    endfunction

    function automatic logic [BYTE-1:0] gf_mul13(input logic [BYTE-1:0] b);
        logic [BYTE-1:0] x4;
        x4 = gf_xtime(gf_xtime(b));
        return gf_xtime(x4) ^ x4 ^ b;
    endfunction

    function automatic logic [BYTE-1:0] gf_mul14(input logic [BYTE-1:0] b);
        logic [BYTE-1:0] x2;
        logic [BYTE-1:0] x4;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        return gf_xtime(x4) ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns transform of one 32-bit column (row 0 in the MSB byte).
// With INV_MIX_COLUMNS_EN defined, inv=1 selects InvMixColumns; otherwise inv is ignored.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [WORD-1:0] col_in,
    input  logic            inv,
    output logic [WORD-1:0] col_out
);

    logic [BYTE-1:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_in;

    always_comb begin
        // NOTE: col_out gets a full default first so the optional inverse branch can never infer a latch.
        col_out = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3,
                   a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                   a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3),
                   gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3)};
`ifdef INV_MIX_COLUMNS_EN
        if (inv) begin
            col_out = {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                       gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                       gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                       gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
        end
`endif
    end

`ifndef INV_MIX_COLUMNS_EN
    logic unused_inv;
    assign unused_inv = inv;
`endif

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Define INV_MIX_COLUMNS_EN to honour in_inv (InvMixColumns); otherwise every transaction is forward.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SENTENCE-1:0] in_state,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SENTENCE-1:0] out_state
);

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_t            state;
    logic [1:0]      col_cnt;
    state_t          work;
    state_t          work_next;
    logic            inv_sel;
    logic            accept;
    logic            last_group;
    logic [WORD-1:0] col_src [COLS_PER_CYCLE];
    logic [WORD-1:0] col_res [COLS_PER_CYCLE];

    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_group = (col_cnt == CNT_LAST);

`ifdef INV_MIX_COLUMNS_EN
    logic inv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= in_inv;
        end
    end

    assign inv_sel = inv_q;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
    assign inv_sel    = 1'b0;
`endif

    // Lane g works on column col_cnt+g; col_cnt is always a multiple of COLS_PER_CYCLE, so no lane wraps.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_src[g] = work[2'd3 - (col_cnt + 2'(g))];

        mix_column_word u_word (
            .col_in  (col_src[g]),
            .inv     (inv_sel),
            .col_out (col_res[g])
        );
    end

    always_comb begin
        work_next = work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            work_next[2'd3 - (col_cnt + 2'(g))] = col_res[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the work register is reset too, so an abandoned transaction leaves nothing behind.
            state     <= IDLE;
            col_cnt   <= '0;
            work      <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
            if (accept) begin
                work    <= in_state;
                col_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    work    <= work_next;
                    col_cnt <= col_cnt + CNT_STEP;
                    if (last_group) begin
                        state     <= DONE;
                        out_state <= work_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? CALC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
